// File: rtl/farrow_pkg.sv
// rtl/farrow_pkg.sv - shared widths, FSM states and output round/saturate helper
package farrow_pkg;
    localparam int DEF_DATA_W = 13;
    localparam int DEF_MU_W   = 11;

    typedef enum logic [1:0] {IDLE, PRIME, RUN, STALL} state_t;

    // Round half up by 'shift' fraction bits, then clamp to a signed 'width'-bit range.
    function automatic logic signed [31:0] sat_round(input logic signed [63:0] acc,
                                                     input int shift, input int width);
        logic signed [63:0] r, hi, lo;
        r  = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (r > hi)      r = hi;
        else if (r < lo) r = lo;
        return r[31:0];
    endfunction
endpackage

// File: rtl/farrow_coef.sv
// rtl/farrow_coef.sv - registered Farrow coefficients (alpha=0.5) from the tap line
module farrow_coef
    import farrow_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] x0,
    input  logic signed [DATA_W-1:0] x1,
    input  logic signed [DATA_W-1:0] x2,
    input  logic signed [DATA_W-1:0] x3,
    output logic signed [DATA_W-1:0] v0,
    output logic signed [DATA_W+2:0] v1,
    output logic signed [DATA_W+2:0] v2
);
    localparam int VW = DATA_W + 3;

    logic signed [VW-1:0] e0, e1, e2, e3;

    assign e0 = VW'(x0);
    assign e1 = VW'(x1);
    assign e2 = VW'(x2);
    assign e3 = VW'(x3);

    // v1/v2 are held doubled (one fraction bit) so the halving stays exact.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v0 <= '0;
            v1 <= '0;
            v2 <= '0;
        end else begin
            v0 <= x2;
            v1 <= (e1 <<< 1) + e1 - e0 - e2 - e3;
            v2 <= e0 - e1 - e2 + e3;
        end
    end
endmodule

// File: rtl/farrow_parabolic_interp_ctrl.sv
// rtl/farrow_parabolic_interp_ctrl.sv - input FIFO, mu NCO, control FSM and Horner datapath
module farrow_parabolic_interp_ctrl
    import farrow_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int MU_W       = DEF_MU_W,
    parameter int FIFO_DEPTH = 4,
    parameter int PIPE       = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [MU_W-1:0]          mu_step,
    input  logic signed [DATA_W-1:0] in_x,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic signed [DATA_W-1:0] out_y,
    output logic [MU_W-1:0]          out_mu,
    output logic                     out_valid
);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int VW   = DATA_W + 3;
    localparam int P1W  = VW + MU_W + 1;
    localparam int TW   = P1W + 1;
    localparam int AW   = TW + MU_W + 2;
    localparam int FRAC = 2 * MU_W + 1;

    logic signed [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]            wr_ptr, rd_ptr;
    logic [PW:0]              count;
    logic                     empty, full, push, pop, ready_en, issue;
    state_t                   state;
    logic [1:0]               prime_cnt;
    logic [MU_W-1:0]          mu_acc, step;
    logic [MU_W:0]            mu_sum;
    logic signed [DATA_W-1:0] x0, x1, x2, x3;

    assign empty    = (count == '0);
    assign full     = (count == (PW + 1)'(FIFO_DEPTH));
    assign issue    = enable && (state == RUN);
    assign mu_sum   = {1'b0, mu_acc} + {1'b0, step};
    assign pop      = enable && !empty &&
                      (state == PRIME || state == STALL || (state == RUN && mu_sum[MU_W]));
    assign in_ready = ready_en && (!full || pop);
    assign push     = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_x;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ready_en  <= 1'b0;
            state     <= IDLE;
            prime_cnt <= '0;
            mu_acc    <= '0;
            step      <= '0;
            x0        <= '0;
            x1        <= '0;
            x2        <= '0;
            x3        <= '0;
        end else begin
            ready_en <= 1'b1;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                x0     <= mem[rd_ptr];
                x1     <= x0;
                x2     <= x1;
                x3     <= x2;
            end
            case ({push, pop})
                2'b10:   count <= count + (PW + 1)'(1);
                2'b01:   count <= count - (PW + 1)'(1);
                default: ;
            endcase
            if (enable) begin
                case (state)
                    IDLE: begin
                        step <= (mu_step == '0) ? MU_W'(1) : mu_step;
                        if (!empty) begin
                            prime_cnt <= '0;
                            state     <= PRIME;
                        end
                    end
                    PRIME: if (!empty) begin
                        prime_cnt <= prime_cnt + 2'd1;
                        if (prime_cnt == 2'd3) state <= RUN;
                    end
                    // A carry with nothing to pop parks here; the pop is owed on resume.
                    RUN: begin
                        mu_acc <= mu_sum[MU_W-1:0];
                        if (mu_sum[MU_W] && empty) state <= STALL;
                    end
                    STALL: if (!empty) state <= RUN;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    logic signed [DATA_W-1:0] v0, v0_2, y3;
    logic signed [VW-1:0]     v1, v2;
    logic [MU_W-1:0]          mu1, mu2, mu3;
    logic                     vld1, vld2, vld3;
    logic signed [MU_W:0]     mu1_s, mu2_s;
    logic signed [P1W-1:0]    p1;
    logic signed [TW-1:0]     t_n, t2;
    logic signed [AW-1:0]     acc_n;

    farrow_coef #(.DATA_W(DATA_W)) u_coef (
        .clk(clk), .rst(rst),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3),
        .v0(v0), .v1(v1), .v2(v2)
    );

    assign mu1_s = signed'({1'b0, mu1});
    assign p1    = P1W'(v2) * P1W'(mu1_s);
    assign t_n   = TW'(p1) + (TW'(v1) <<< MU_W);
    assign mu2_s = signed'({1'b0, mu2});
    assign acc_n = AW'(t2) * AW'(mu2_s) + (AW'(v0_2) <<< FRAC);

    // The datapath ignores enable so in-flight results always drain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mu1  <= '0;
            vld1 <= 1'b0;
            t2   <= '0;
            v0_2 <= '0;
            mu2  <= '0;
            vld2 <= 1'b0;
            y3   <= '0;
            mu3  <= '0;
            vld3 <= 1'b0;
        end else begin
            mu1  <= mu_acc;
            vld1 <= issue;
            t2   <= t_n;
            v0_2 <= v0;
            mu2  <= mu1;
            vld2 <= vld1;
            y3   <= DATA_W'(sat_round(64'(acc_n), FRAC, DATA_W));
            mu3  <= mu2;
            vld3 <= vld2;
        end
    end

    generate
        if (PIPE > 3) begin : g_delay
            localparam int D = PIPE - 3;
            logic signed [DATA_W-1:0] y_d  [D];
            logic [MU_W-1:0]          mu_d [D];
            logic [D-1:0]             vld_d;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    vld_d <= '0;
                    for (int i = 0; i < D; i++) begin
                        y_d[i]  <= '0;
                        mu_d[i] <= '0;
                    end
                end else begin
                    y_d[0]   <= y3;
                    mu_d[0]  <= mu3;
                    vld_d[0] <= vld3;
                    for (int i = 1; i < D; i++) begin
                        y_d[i]   <= y_d[i-1];
                        mu_d[i]  <= mu_d[i-1];
                        vld_d[i] <= vld_d[i-1];
                    end
                end
            end
            assign out_y     = y_d[D-1];
            assign out_mu    = mu_d[D-1];
            assign out_valid = vld_d[D-1];
        end else begin : g_direct
            assign out_y     = y3;
            assign out_mu    = mu3;
            assign out_valid = vld3;
        end
    endgenerate
endmodule
